sobel_stream_ctrl: RTL and testbench

- Streaming frame controller that sequences the team's combinational core_sobel operator over a raster-scan 8-bit greyscale image.
- Accepts pixels over a valid/ready input stream and keeps two line buffers plus a 3x3 window register array.
- Drives the eight neighbour pixels into an internal core_sobel instance and emits one registered edge-magnitude pixel per input pixel, with zeroed borders.
- Sits between the camera/frame-read stage and the VGA/frame-write stage.

---
 rtl/sobel_stream_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_sobel_stream_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_ctrl.sv
// sobel_stream_ctrl: raster-scan frame controller feeding a 3x3 Sobel core from two line buffers.
// Optional macro SOBEL_THRESH_EN adds a thresh input that binarises interior outputs.
module sobel_stream_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_sof,
`ifdef SOBEL_THRESH_EN
  input  logic [7:0] thresh,
`endif
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       frame_done,
  output logic       busy
);
  localparam int DATA_W = 8;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int FW     = $clog2(IMG_W + 2);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [FW-1:0] FLUSH_N  = FW'(IMG_W + 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     in_col_q, in_col_d;
  logic [RW-1:0]     in_row_q, in_row_d;
  logic [FW-1:0]     flush_cnt_q, flush_cnt_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              frame_done_q, frame_done_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;

  logic [DATA_W-1:0] lb0_q [IMG_W];
  logic [DATA_W-1:0] lb1_q [IMG_W];
  logic [DATA_W-1:0] win_q [3][3];

  logic              accept, pix_acc, out_slot, out_hs;
  logic              col_wrap, frame_end, fill_end, border;
  logic [CW-1:0]     wr_col;
  logic [DATA_W-1:0] lb0_rd, lb1_rd, mag, pix_out;

  assign accept    = s_valid & s_ready;
  assign pix_acc   = accept & ((state_q != IDLE) | s_sof);
  assign out_slot  = ~m_valid_q | m_ready;
  assign out_hs    = m_valid_q & m_ready;
  assign col_wrap  = (in_col_q == COL_LAST);
  assign frame_end = col_wrap & (in_row_q == ROW_LAST);
  // Pixel (1,0) is the (IMG_W+1)th beat: the last one needed before the window is centred.
  assign fill_end  = (in_col_q == '0) & (in_row_q == RW'(1));

  // A start-of-frame beat is always pixel (0,0), whatever the counters say.
  assign wr_col = s_sof ? '0 : in_col_q;
  assign lb0_rd = lb0_q[wr_col];
  assign lb1_rd = lb1_q[wr_col];

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign frame_done = frame_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept && s_sof) state_d = FILL;
      FILL:  if (accept && !s_sof && fill_end) state_d = RUN;
      RUN: begin
        if (accept && s_sof)           state_d = FILL;
        else if (accept && frame_end)  state_d = FLUSH;
      end
      FLUSH: if (out_hs && m_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE:  s_ready = 1'b1;
      FILL:  begin s_ready = 1'b1;     busy = 1'b1; end
      RUN:   begin s_ready = out_slot; busy = 1'b1; end
      FLUSH: busy = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    if (pix_acc) begin
      if (s_sof) begin
        in_col_d = CW'(1);
        in_row_d = '0;
      end else if (col_wrap) begin
        in_col_d = '0;
        in_row_d = frame_end ? '0 : in_row_q + 1'b1;
      end else begin
        in_col_d = in_col_q + 1'b1;
      end
    end
  end

  // Stage p0 -> p1: window/line-buffer shift; column 0 holds the column leaving the window.
  always_ff @(posedge clk) begin
    if (pix_acc) begin
      lb0_q[wr_col] <= lb1_rd;
      lb1_q[wr_col] <= s_data;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb0_rd;
      win_q[1][2] <= lb1_rd;
      win_q[2][2] <= s_data;
    end
  end

  core_sobel #(.DATA_W(DATA_W)) u_core (
    .p_nw (win_q[0][1]),
    .p_n  (win_q[0][2]),
    .p_ne (lb0_rd),
    .p_w  (win_q[1][1]),
    .p_e  (lb1_rd),
    .p_sw (win_q[2][1]),
    .p_s  (win_q[2][2]),
    .p_se (s_data),
    .mag  (mag)
  );

  always_comb begin
    border = (in_row_q < RW'(2)) | (in_col_q < CW'(2));
`ifdef SOBEL_THRESH_EN
    pix_out = border ? '0 : ((mag >= thresh) ? 8'hFF : 8'h00);
`else
    pix_out = border ? '0 : mag;
`endif
  end

  always_comb begin
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    flush_cnt_d  = flush_cnt_q;
    frame_done_d = out_hs & m_last_q;
    if (out_hs) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
    if (state_q == RUN && accept && !s_sof) begin
      m_valid_d = 1'b1;
      m_data_d  = pix_out;
      m_last_d  = 1'b0;
    end
    if (state_q == FLUSH && out_slot && flush_cnt_q != FLUSH_N) begin
      m_valid_d   = 1'b1;
      m_data_d    = '0;
      m_last_d    = (flush_cnt_q == FLUSH_N - 1'b1);
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
    if (state_q != FLUSH) flush_cnt_d = '0;
  end

  // Stage p1 -> p2: registered output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_col_q     <= '0;
      in_row_q     <= '0;
      flush_cnt_q  <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      flush_cnt_q  <= flush_cnt_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// core_sobel: combinational |Gx|+|Gy| over the eight neighbours, saturated to DATA_W bits.
module core_sobel #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] p_nw,
  input  logic [DATA_W-1:0] p_n,
  input  logic [DATA_W-1:0] p_ne,
  input  logic [DATA_W-1:0] p_w,
  input  logic [DATA_W-1:0] p_e,
  input  logic [DATA_W-1:0] p_sw,
  input  logic [DATA_W-1:0] p_s,
  input  logic [DATA_W-1:0] p_se,
  output logic [DATA_W-1:0] mag
);
  localparam int SW = DATA_W + 4;

  logic signed [SW-1:0] gx, gy;
  logic        [SW-1:0] sum;

  function automatic logic signed [SW-1:0] ext(input logic [DATA_W-1:0] p);
    return $signed({{(SW - DATA_W){1'b0}}, p});
  endfunction

  function automatic logic [SW-1:0] abs_s(input logic signed [SW-1:0] v);
    return (v < 0) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [DATA_W-1:0] sat_u(input logic [SW-1:0] v);
    return (|v[SW-1:DATA_W]) ? {DATA_W{1'b1}} : v[DATA_W-1:0];
  endfunction

  always_comb begin
    gx  = (ext(p_ne) + (ext(p_e) <<< 1) + ext(p_se)) - (ext(p_nw) + (ext(p_w) <<< 1) + ext(p_sw));
    gy  = (ext(p_sw) + (ext(p_s) <<< 1) + ext(p_se)) - (ext(p_nw) + (ext(p_n) <<< 1) + ext(p_ne));
    sum = abs_s(gx) + abs_s(gy);
    mag = sat_u(sum);
  end
endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Self-checking bench for sobel_stream_ctrl on a 5x4 image against a direct Sobel model.
`timescale 1ns/1ps
module tb_sobel_stream_ctrl;
  localparam int W = 5;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       s_sof = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_last;
  logic       frame_done;
  logic       busy;
`ifdef SOBEL_THRESH_EN
  logic [7:0] thresh = '0;
`endif

  int n_pass = 0;
  int n_chk  = 0;

  int img [H][W];
  int kx [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  int ky [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
  int exp_q [$];
  int thr_en  = 0;
  int thr_val = 0;

  logic [7:0] cap_data [$];
  logic       cap_last [$];
  int cyc = 0, fd_cnt = 0, fd_cyc = -1, last_cyc = -1;
  int stall_err = 0, flush_rdy_err = 0;
  bit in_flush = 1'b0;
  int rdy_mode = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  sobel_stream_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_sof      (s_sof),
`ifdef SOBEL_THRESH_EN
    .thresh     (thresh),
`endif
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(1));
    endcase
  end

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stall_err++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (in_flush && s_ready) flush_rdy_err++;
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (m_valid && m_ready) begin
        cap_data.push_back(m_data);
        cap_last.push_back(m_last);
        if (m_last) begin
          last_cyc = cyc;
          in_flush = 1'b0;
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic int model_pix(input int r, input int c);
    int gx = 0;
    int gy = 0;
    int m;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        gx += kx[i][j] * img[r + i - 1][c + j - 1];
        gy += ky[i][j] * img[r + i - 1][c + j - 1];
      end
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (m > 255) m = 255;
    if (thr_en != 0) m = (m >= thr_val) ? 255 : 0;
    return m;
  endfunction

  task automatic append_expected();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) exp_q.push_back(model_pix(r, c));
  endtask

  task automatic fill_image(input int kind, input int val);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0: img[r][c] = val;
          1: img[r][c] = 10 * c;
          2: img[r][c] = (c < 2) ? 0 : 200;
          default: img[r][c] = int'($urandom_range(255));
        endcase
  endtask

  task automatic clear_cap();
    cap_data.delete();
    cap_last.delete();
    exp_q.delete();
    fd_cnt = 0;
    fd_cyc = -1;
    last_cyc = -1;
    stall_err = 0;
    flush_rdy_err = 0;
  endtask

  task automatic send_beat(input logic [7:0] d, input bit sof, input int gap_pct, output bit ok);
    int guard = 0;
    while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    ok = 1'b0;
    while (!ok && guard < 200) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk); #1;
      guard++;
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic send_frame(input int gap_pct, input int beats);
    bit ok;
    for (int k = 0; k < beats; k++) begin
      send_beat(8'(img[k / W][k % W]), k == 0, gap_pct, ok);
      if (!ok) begin
        n_chk++;
        $display("FAIL send_accept: beat %0d not accepted, s_ready=%b required 1", k, s_ready);
        return;
      end
    end
    if (beats == N) in_flush = 1'b1;
  endtask

  task automatic wait_caps(input int n);
    int t = 0;
    while (cap_data.size() < n && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else n_pass++;
    n_chk++; if (m_data !== 8'd0) $display("FAIL reset_m_data: got %0d want 0", m_data); else n_pass++;
    n_chk++; if (m_last !== 1'b0) $display("FAIL reset_m_last: got %b want 0", m_last); else n_pass++;
    n_chk++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b want 1", s_ready); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_constant();
    clear_cap();
    rdy_mode = 0;
    fill_image(0, 100);
    append_expected();
    send_frame(0, N);
    wait_caps(N);
    n_chk++; if (cap_data.size() != N) $display("FAIL const_count: got %0d want %0d", cap_data.size(), N); else n_pass++;
    for (int i = 0; i < cap_data.size() && i < N; i++) begin
      n_chk++;
      if (cap_data[i] !== 8'(exp_q[i]) || cap_last[i] !== (i == N - 1))
        $display("FAIL const_px%0d: got %0d/last%b want %0d/last%b", i, cap_data[i], cap_last[i], exp_q[i], i == N - 1);
      else n_pass++;
    end
    n_chk++; if (fd_cnt != 1) $display("FAIL const_fd_count: got %0d want 1", fd_cnt); else n_pass++;
    n_chk++; if (fd_cyc != last_cyc + 1) $display("FAIL const_fd_timing: got cycle %0d want %0d", fd_cyc, last_cyc + 1); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL const_idle_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_patterns();
    for (int p = 0; p < 4; p++) begin
      clear_cap();
      rdy_mode = 0;
      fill_image(p == 0 ? 1 : (p == 1 ? 2 : 3), 0);
      append_expected();
      send_frame(0, N);
      wait_caps(N);
      n_chk++; if (cap_data.size() != N) $display("FAIL pat%0d_count: got %0d want %0d", p, cap_data.size(), N); else n_pass++;
      for (int i = 0; i < cap_data.size() && i < N; i++) begin
        n_chk++;
        if (cap_data[i] !== 8'(exp_q[i]) || cap_last[i] !== (i == N - 1))
          $display("FAIL pat%0d_px%0d: got %0d/last%b want %0d/last%b", p, i, cap_data[i], cap_last[i], exp_q[i], i == N - 1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_cap();
    rdy_mode = 1;
    fill_image(1, 0);
    append_expected();
    send_frame(30, N);
    rdy_mode = 2;
    fill_image(3, 0);
    append_expected();
    send_frame(30, N);
    wait_caps(2 * N);
    rdy_mode = 0;
    n_chk++; if (cap_data.size() != 2 * N) $display("FAIL b2b_count: got %0d want %0d", cap_data.size(), 2 * N); else n_pass++;
    for (int i = 0; i < cap_data.size() && i < 2 * N; i++) begin
      n_chk++;
      if (cap_data[i] !== 8'(exp_q[i]) || cap_last[i] !== (i % N == N - 1))
        $display("FAIL b2b_px%0d: got %0d/last%b want %0d/last%b", i, cap_data[i], cap_last[i], exp_q[i], i % N == N - 1);
      else n_pass++;
    end
    n_chk++; if (stall_err != 0) $display("FAIL b2b_stall_hold: got %0d changes want 0", stall_err); else n_pass++;
    n_chk++; if (flush_rdy_err != 0) $display("FAIL b2b_flush_ready: got %0d ready cycles want 0", flush_rdy_err); else n_pass++;
    n_chk++; if (fd_cnt != 2) $display("FAIL b2b_fd_count: got %0d want 2", fd_cnt); else n_pass++;
  endtask

  task automatic test_abort();
    int partial;
    clear_cap();
    rdy_mode = 0;
    fill_image(1, 0);
    send_frame(0, 7);
    partial = (7 > W + 1) ? 7 - (W + 1) : 0;
    for (int i = 0; i < partial; i++) exp_q.push_back(0);
    fill_image(0, 50);
    append_expected();
    send_frame(0, N);
    wait_caps(N + partial);
    n_chk++; if (cap_data.size() != N + partial) $display("FAIL abort_count: got %0d want %0d", cap_data.size(), N + partial); else n_pass++;
    for (int i = 0; i < cap_data.size() && i < N + partial; i++) begin
      n_chk++;
      if (cap_data[i] !== 8'(exp_q[i]) || cap_last[i] !== (i == N + partial - 1))
        $display("FAIL abort_px%0d: got %0d/last%b want %0d/last%b", i, cap_data[i], cap_last[i], exp_q[i], i == N + partial - 1);
      else n_pass++;
    end
    n_chk++; if (fd_cnt != 1) $display("FAIL abort_fd_count: got %0d want 1", fd_cnt); else n_pass++;
  endtask

  task automatic test_idle_drop();
    bit ok;
    clear_cap();
    rdy_mode = 2;
    for (int k = 0; k < 3; k++) send_beat(8'($urandom_range(255)), 1'b0, 0, ok);
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL idle_drop_busy: got %b want 0", busy); else n_pass++;
    @(posedge clk); #1;
    fill_image(3, 0);
    append_expected();
    send_frame(20, N);
    wait_caps(N);
    rdy_mode = 0;
    n_chk++; if (cap_data.size() != N) $display("FAIL idle_drop_count: got %0d want %0d", cap_data.size(), N); else n_pass++;
    for (int i = 0; i < cap_data.size() && i < N; i++) begin
      n_chk++;
      if (cap_data[i] !== 8'(exp_q[i])) $display("FAIL idle_drop_px%0d: got %0d want %0d", i, cap_data[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    clear_cap();
    rdy_mode = 0;
    fill_image(3, 0);
    send_frame(0, 12);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (m_valid !== 1'b0) $display("FAIL arst_m_valid: got %b want 0", m_valid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", busy); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_cap();
    fill_image(2, 0);
    append_expected();
    send_frame(0, N);
    wait_caps(N);
    n_chk++; if (cap_data.size() != N) $display("FAIL arst_count: got %0d want %0d", cap_data.size(), N); else n_pass++;
    for (int i = 0; i < cap_data.size() && i < N; i++) begin
      n_chk++;
      if (cap_data[i] !== 8'(exp_q[i])) $display("FAIL arst_px%0d: got %0d want %0d", i, cap_data[i], exp_q[i]);
      else n_pass++;
    end
  endtask

`ifdef SOBEL_THRESH_EN
  task automatic test_thresh();
    for (int t = 0; t < 2; t++) begin
      clear_cap();
      rdy_mode = 0;
      thr_en  = 1;
      thr_val = (t == 0) ? 81 : 80;
      thresh  = 8'(thr_val);
      fill_image(1, 0);
      append_expected();
      send_frame(0, N);
      wait_caps(N);
      n_chk++; if (cap_data.size() != N) $display("FAIL thr%0d_count: got %0d want %0d", thr_val, cap_data.size(), N); else n_pass++;
      for (int i = 0; i < cap_data.size() && i < N; i++) begin
        n_chk++;
        if (cap_data[i] !== 8'(exp_q[i])) $display("FAIL thr%0d_px%0d: got %0d want %0d", thr_val, i, cap_data[i], exp_q[i]);
        else n_pass++;
      end
    end
    thr_en = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_constant();
    test_patterns();
    test_back_to_back();
    test_abort();
    test_idle_drop();
    test_async_reset();
`ifdef SOBEL_THRESH_EN
    test_thresh();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
